// File: rtl/score_counter_pkg.sv
// Shared definitions for the score counter and its neighbouring stages
// (display and game control): state encodings, score width and ceiling,
// plus the saturating add used to build the next score.
package score_counter_pkg;

    // Width of every score value travelling between stages.
    localparam int SCORE_W = 32;

    // Largest score the four-digit display can show.
    localparam int MAX_SCORE = 9999;

    // Game state as seen by the display and game-control stages.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    // Adds two scores one bit wider than the operands, so the sum never
    // wraps, then clamps the result to the given ceiling.
    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] a,
        input logic [SCORE_W-1:0] b,
        input logic [SCORE_W-1:0] ceiling
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, ceiling}) begin
            sat_add = ceiling;
        end else begin
            sat_add = sum[SCORE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/score_counter_if.sv
// Bundle of game-control inputs and score outputs shared between the
// game-control side (master) and the score counter (slave).
interface score_counter_if;
    import score_counter_pkg::*;

    // Game-control events and level
    logic               start;
    logic               running;
    logic               game_over;
    logic               bonus;

    // Score results for the display stage
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic               new_high;
    logic               score_tick;
    state_e             state;

    // Game-control side: drives events, observes the score
    modport master (
        output start,
        output running,
        output game_over,
        output bonus,
        input  score,
        input  high_score,
        input  new_high,
        input  score_tick,
        input  state
    );

    // Score counter side: consumes events, produces the score
    modport slave (
        input  start,
        input  running,
        input  game_over,
        input  bonus,
        output score,
        output high_score,
        output new_high,
        output score_tick,
        output state
    );

endinterface

// File: rtl/score_counter_tick_prescaler.sv
// Enable-gated modulo-DIV counter. Emits a single-cycle wrap pulse in the
// cycle it rolls over from DIV-1 back to zero. Clear has priority over
// enable so a restart never produces a stray wrap. Also suitable for pacing
// obstacle speed.
module score_counter_tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic wrap
);

    // At least one bit, so DIV=1 still builds and wraps every enabled cycle.
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear, hold when disabled, otherwise step and wrap at LAST.
    always_comb begin
        count_d = count_q;
        wrap    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (count_q == LAST) begin
                count_d = '0;
                wrap    = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/score_counter.sv
// Score counter for the runner game. Awards one point per prescaler period
// while running, adds bonus points on request, saturates at the display
// ceiling, freezes on game over, and keeps the best score across games
// until reset.
module score_counter
    import score_counter_pkg::*;
#(
    parameter int TICK_DIV  = 10_000_000,
    parameter int BONUS_PTS = 50,
    parameter int MAX_SCORE = score_counter_pkg::MAX_SCORE
) (
    input  logic           clk,
    input  logic           reset,
    score_counter_if.slave bus
);

    localparam logic [SCORE_W-1:0] MAX_VAL   = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] BONUS_VAL = SCORE_W'(BONUS_PTS);
    localparam logic [SCORE_W-1:0] ONE_VAL   = SCORE_W'(1);

    state_e             state_q;
    state_e             state_d;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_d;
    logic [SCORE_W-1:0] high_score_q;
    logic [SCORE_W-1:0] high_score_d;
    logic               new_high_q;
    logic               new_high_d;
    logic               score_tick_q;
    logic               score_tick_d;

    logic               pre_clear;
    logic               pre_enable;
    logic               point_tick;
    logic [SCORE_W-1:0] inc;
    logic [SCORE_W-1:0] score_sat;
    logic               restart;

    // A start begins a fresh game unless game_over claims the same cycle in RUN.
    assign restart = bus.start && !((state_q == ST_RUN) && bus.game_over);

    // Prescaler control depends only on registered state and inputs, keeping
    // it free of any path back from the score logic.
    always_comb begin
        pre_clear  = restart;
        pre_enable = (state_q == ST_RUN) && bus.running && !bus.game_over;
    end

    score_counter_tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (pre_clear),
        .enable (pre_enable),
        .wrap   (point_tick)
    );

    // Points earned this cycle and the clamped score they would produce.
    always_comb begin
        inc       = (point_tick ? ONE_VAL : '0) + (bus.bonus ? BONUS_VAL : '0);
        score_sat = sat_add(score_q, inc, MAX_VAL);
    end

    // Game FSM: next state, score, high score and new-high flag.
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        high_score_d = high_score_q;
        new_high_d   = new_high_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_RUN;
                    score_d    = '0;
                    new_high_d = 1'b0;
                end
            end

            ST_RUN: begin
                if (bus.game_over) begin
                    state_d = ST_OVER;
                    if (score_q > high_score_q) begin
                        high_score_d = score_q;
                    end
                end else if (bus.start) begin
                    score_d    = '0;
                    new_high_d = 1'b0;
                end else begin
                    score_d = score_sat;
                    if (score_sat > high_score_q) begin
                        new_high_d = 1'b1;
                    end
                end
            end

            ST_OVER: begin
                if (bus.start) begin
                    state_d    = ST_RUN;
                    score_d    = '0;
                    new_high_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        score_tick_d = (score_d != score_q);
    end

    // State and score registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            score_q      <= '0;
            high_score_q <= '0;
            new_high_q   <= 1'b0;
            score_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            high_score_q <= high_score_d;
            new_high_q   <= new_high_d;
            score_tick_q <= score_tick_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.high_score = high_score_q;
    assign bus.new_high   = new_high_q;
    assign bus.score_tick = score_tick_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter with a 4-cycle prescaler: hand-written
// sequences for the opening run and pause, then a table of held-input
// steps with expected outputs after the last cycle of each step.
module tb_score_counter;
    import score_counter_pkg::*;

    logic clk;
    logic reset;

    int checks;
    int errors;

    score_counter_if bus_if ();

    score_counter #(
        .TICK_DIV  (4),
        .BONUS_PTS (50),
        .MAX_SCORE (9999)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One table step: inputs held for 'cycles' edges, then outputs checked.
    // exp_tick of -1 means score_tick is not checked for that step.
    typedef struct {
        int rst;
        int st;
        int run;
        int go;
        int bon;
        int cycles;
        int exp_score;
        int exp_high;
        int exp_nh;
        int exp_tick;
        int exp_state;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input int rst, input int st, input int run, input int go,
                          input int bon, input int cycles, input int exp_score,
                          input int exp_high, input int exp_nh, input int exp_tick,
                          input int exp_state);
        vec_t v;
        v.rst = rst; v.st = st; v.run = run; v.go = go; v.bon = bon;
        v.cycles = cycles; v.exp_score = exp_score; v.exp_high = exp_high;
        v.exp_nh = exp_nh; v.exp_tick = exp_tick; v.exp_state = exp_state;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input int rst, input int st, input int run,
                                 input int go, input int bon);
        reset             = (rst != 0);
        bus_if.start      = (st != 0);
        bus_if.running    = (run != 0);
        bus_if.game_over  = (go != 0);
        bus_if.bonus      = (bon != 0);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int exp_score, input int exp_high,
                               input int exp_nh, input int exp_tick, input int exp_state);
        int act_state;
        act_state = int'(bus_if.state);

        checks++;
        if (bus_if.score !== 32'(exp_score)) begin
            errors++;
            $display("[TB] FAIL %s score: got %0d expected %0d", name, bus_if.score, exp_score);
        end
        checks++;
        if (bus_if.high_score !== 32'(exp_high)) begin
            errors++;
            $display("[TB] FAIL %s high_score: got %0d expected %0d", name, bus_if.high_score, exp_high);
        end
        checks++;
        if (bus_if.new_high !== (exp_nh != 0)) begin
            errors++;
            $display("[TB] FAIL %s new_high: got %0b expected %0d", name, bus_if.new_high, exp_nh);
        end
        if (exp_tick >= 0) begin
            checks++;
            if (bus_if.score_tick !== (exp_tick != 0)) begin
                errors++;
                $display("[TB] FAIL %s score_tick: got %0b expected %0d", name, bus_if.score_tick, exp_tick);
            end
        end
        checks++;
        if (act_state != exp_state) begin
            errors++;
            $display("[TB] FAIL %s state: got %0d expected %0d", name, act_state, exp_state);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset for two cycles
        applyStimulus(1, 0, 0, 0, 0);
        stepCycle();
        stepCycle();
        checkOutput("reset", 0, 0, 0, 0, 0);

        // Start a game, then run 40 cycles: a point every 4th cycle
        applyStimulus(0, 1, 0, 0, 0);
        stepCycle();
        checkOutput("start", 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            stepCycle();
            checkOutput($sformatf("run%0d", k), k / 4, 0, (k >= 4) ? 1 : 0,
                        (k % 4 == 0) ? 1 : 0, 1);
        end

        // Two more cycles leave the prescaler at 2, then pause for 20
        stepCycle();
        stepCycle();
        checkOutput("prepause", 10, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            stepCycle();
            checkOutput($sformatf("pause%0d", k), 10, 0, 1, 0, 1);
        end

        // Resume: prescaler 2 -> 3, then the next cycle awards a point
        applyStimulus(0, 0, 1, 0, 0);
        stepCycle();
        checkOutput("resume1", 10, 0, 1, 0, 1);
        stepCycle();
        checkOutput("resume2", 11, 0, 1, 1, 1);

        //      rst st run go bon  n    score high nh tick state
        // Restart in RUN, reach 7, then bonus on the point-tick cycle
        addVec(0, 1, 0, 0, 0,   1,     0,   0, 0, -1, 1);
        addVec(0, 0, 1, 0, 0,  28,     7,   0, 1,  1, 1);
        addVec(0, 0, 1, 0, 0,   3,     7,   0, 1,  0, 1);
        addVec(0, 0, 1, 0, 1,   1,    58,   0, 1,  1, 1);
        addVec(0, 0, 0, 0, 0,   1,    58,   0, 1,  0, 1);
        // Climb to 9990 (bonus while paused, then ticks), then saturate
        addVec(0, 1, 0, 0, 0,   1,     0,   0, 0, -1, 1);
        addVec(0, 0, 0, 0, 1, 199,  9950,   0, 1,  1, 1);
        addVec(0, 0, 1, 0, 0, 160,  9990,   0, 1,  1, 1);
        addVec(0, 0, 0, 0, 1,   1,  9999,   0, 1,  1, 1);
        addVec(0, 0, 0, 0, 1,   2,  9999,   0, 1,  0, 1);
        addVec(0, 0, 1, 0, 0,   8,  9999,   0, 1,  0, 1);
        // Reset mid-game, inputs ignored in IDLE
        addVec(1, 0, 0, 0, 0,   1,     0,   0, 0,  0, 0);
        addVec(0, 0, 1, 1, 1,   3,     0,   0, 0,  0, 0);
        // Game 1 ends at 30; OVER ignores bonus and running
        addVec(0, 1, 0, 0, 0,   1,     0,   0, 0,  0, 1);
        addVec(0, 0, 1, 0, 0, 120,    30,   0, 1,  1, 1);
        addVec(0, 0, 0, 1, 0,   1,    30,  30, 1,  0, 2);
        addVec(0, 0, 1, 0, 1,   5,    30,  30, 1,  0, 2);
        // Game 2 ends at 12; game_over beats a simultaneous start
        addVec(0, 1, 0, 0, 0,   1,     0,  30, 0, -1, 1);
        addVec(0, 0, 1, 0, 0,  48,    12,  30, 0,  1, 1);
        addVec(0, 1, 0, 1, 0,   1,    12,  30, 0,  0, 2);
        // Game 3 ties at 30, beats it at 31
        addVec(0, 1, 0, 0, 0,   1,     0,  30, 0, -1, 1);
        addVec(0, 0, 1, 0, 0, 120,    30,  30, 0,  1, 1);
        addVec(0, 0, 1, 0, 0,   4,    31,  30, 1,  1, 1);
        addVec(0, 0, 0, 1, 0,   1,    31,  31, 1,  0, 2);
        // Game over with bonus and a due point tick: score frozen
        addVec(0, 1, 0, 0, 0,   1,     0,  31, 0, -1, 1);
        addVec(0, 0, 1, 0, 0,  11,     2,  31, 0,  0, 1);
        addVec(0, 0, 1, 1, 1,   1,     2,  31, 0,  0, 2);
        // Reset and start together: reset wins
        addVec(1, 1, 0, 0, 0,   1,     0,   0, 0,  0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].run, vecs[i].go, vecs[i].bon);
            for (int c = 0; c < vecs[i].cycles; c++) begin
                stepCycle();
            end
            checkOutput($sformatf("row%0d", i), vecs[i].exp_score, vecs[i].exp_high,
                        vecs[i].exp_nh, vecs[i].exp_tick, vecs[i].exp_state);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
